// File: rtl/tw4_system_pkg.sv
// Shared types for the tw4_system microcomputer: bus word types, the
// instruction opcode encoding, the interrupt vector and the built-in ROM image.
package tw4_system_pkg;

  typedef logic [7:0] data_t;
  typedef logic [3:0] addr_t;
  typedef logic [3:0] nib_t;

  typedef enum logic [3:0] {
    OP_ADD_A    = 4'b0000,
    OP_MOV_AB   = 4'b0001,
    OP_IN_A     = 4'b0010,
    OP_MOV_A_IM = 4'b0011,
    OP_MOV_BA   = 4'b0100,
    OP_ADD_B    = 4'b0101,
    OP_IN_B     = 4'b0110,
    OP_MOV_B_IM = 4'b0111,
    OP_EI       = 4'b1000,
    OP_OUT_B    = 4'b1001,
    OP_RETI     = 4'b1010,
    OP_OUT_IM   = 4'b1011,
    OP_JNC      = 4'b1110,
    OP_JMP      = 4'b1111
  } opcode_e;

  localparam addr_t       ISR_VECTOR  = 4'hC;
  localparam int unsigned NUM_BUTTONS = 4;

  // Built-in program: enable button 0, clear the LEDs, idle at 3;
  // the ISR at 0xC increments B and shows it on the LEDs.
  function automatic data_t rom_word(input addr_t a);
    data_t w;
    case (a)
      4'h0:    w = 8'h81;
      4'h1:    w = 8'h70;
      4'h2:    w = 8'hB0;
      4'hC:    w = 8'h51;
      4'hD:    w = 8'h90;
      4'hE:    w = 8'hA0;
      default: w = 8'hF3;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/tw4_system_if.sv
// CPU-side bus of tw4_system.
//   addr/data : instruction fetch (CPU -> ROM address, ROM -> CPU word)
//   ack       : interrupt acknowledge, high in the accepting cycle only
//   ie        : per-button interrupt enables held by the CPU
//   irq       : resolved interrupt request (z/x already folded to 0)
interface tw4_system_if import tw4_system_pkg::*; ();
  addr_t addr;
  data_t data;
  logic  ack;
  nib_t  ie;
  logic  irq;

  modport master (output addr, output ack, output ie, input data, input irq);
  modport slave  (input addr, input ack, input ie, output data, output irq);
endinterface

// File: rtl/tw4_system_button.sv
// button: one interrupt source in the IEI/IEO daisy chain.
//   clock : system clock        in  : raw button level
//   ack   : CPU acknowledge     ie  : enable for this source
//   iei   : chain enable in     ieo : chain enable out
//   irq   : shared open line, driven 1 or released to z
// No reset: the CPU holds ie low while in reset, which clears pending.
module button (
  input  logic clock,
  input  logic in,
  input  logic ack,
  input  logic ie,
  input  logic iei,
  output logic ieo,
  output wire  irq
);
  logic prev;
  logic pending;

  // A fresh edge wins over an acknowledge landing on the same clock.
  always_ff @(posedge clock) begin
    prev <= in;
    if (!ie)
      pending <= 1'b0;
    else if (in && !prev)
      pending <= 1'b1;
    else if (ack && iei && pending)
      pending <= 1'b0;
  end

  assign irq = (pending && iei) ? 1'b1 : 1'bz;
  assign ieo = iei && !pending;
endmodule

// File: rtl/tw4_system_cpu.sv
// cpu: single-cycle TD4-style 4-bit core with one-level interrupt support.
//   clock, reset (async active-low)
//   bus : fetch address/data, ack, ie, resolved irq
//   in  : input port for IN A / IN B
//   out : LED output register
module cpu import tw4_system_pkg::*; (
  input  logic clock,
  input  logic reset,
  tw4_system_if.master bus,
  input  nib_t in,
  output nib_t out
);
  nib_t    a, b, ie;
  addr_t   pc, spc;
  logic    c, sc, in_isr;
  opcode_e op;
  nib_t    im;
  logic [4:0] sum_a, sum_b;
  logic    take_irq;

  always_comb begin
    op       = opcode_e'(bus.data[7:4]);
    im       = bus.data[3:0];
    sum_a    = {1'b0, a} + {1'b0, im};
    sum_b    = {1'b0, b} + {1'b0, im};
    take_irq = bus.irq && !in_isr;
  end

  assign bus.addr = pc;
  assign bus.ack  = take_irq;
  assign bus.ie   = ie;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a      <= '0;
      b      <= '0;
      c      <= 1'b0;
      pc     <= '0;
      out    <= '0;
      ie     <= '0;
      in_isr <= 1'b0;
      spc    <= '0;
      sc     <= 1'b0;
    end else if (take_irq) begin
      // The fetched instruction is discarded; it re-executes after RETI.
      spc    <= pc;
      sc     <= c;
      pc     <= ISR_VECTOR;
      in_isr <= 1'b1;
    end else begin
      pc <= pc + 4'd1;
      c  <= 1'b0;
      case (op)
        OP_ADD_A:    {c, a} <= sum_a;
        OP_ADD_B:    {c, b} <= sum_b;
        OP_MOV_A_IM: a <= im;
        OP_MOV_B_IM: b <= im;
        OP_MOV_AB:   a <= b;
        OP_MOV_BA:   b <= a;
        OP_IN_A:     a <= in;
        OP_IN_B:     b <= in;
        OP_OUT_B:    out <= b;
        OP_OUT_IM:   out <= im;
        OP_JMP:      pc <= im;
        OP_JNC:      if (!c) pc <= im;
        OP_EI:       ie <= im;
        OP_RETI: begin
          pc     <= spc;
          c      <= sc;
          in_isr <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/tw4_system_memory.sv
// memory: combinational 16x8 ROM holding the built-in program.
//   bus.addr in, bus.data out (valid in the same cycle).
module memory import tw4_system_pkg::*; (
  tw4_system_if.slave bus
);
  assign bus.data = rom_word(bus.addr);
endmodule

// File: rtl/tw4_system.sv
// tw4_system: TD4-style microcomputer with four daisy-chained interrupt
// buttons sharing one tri-state request line.
//   clock : system clock
//   reset : asynchronous active-low reset
//   in    : button inputs (bit n -> button n), also the IN port
//   out   : LED register
module tw4_system import tw4_system_pkg::*; (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] in,
  output logic [3:0] out
);
  tw4_system_if bus ();

  wire  irq_net;
  logic [NUM_BUTTONS:0] chain;
  logic unused_chain_end;

  assign chain[0]         = 1'b1;
  assign unused_chain_end = chain[NUM_BUTTONS];

  cpu u_cpu (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master),
    .in    (in),
    .out   (out)
  );

  memory u_memory (
    .bus (bus.slave)
  );

  for (genvar n = 0; n < NUM_BUTTONS; n++) begin : g_button
    button u_button (
      .clock (clock),
      .in    (in[n]),
      .ack   (bus.ack),
      .ie    (bus.ie[n]),
      .iei   (chain[n]),
      .ieo   (chain[n+1]),
      .irq   (irq_net)
    );
  end

  // Released line (z) or contention (x) must read as no request.
  assign bus.irq = (irq_net === 1'b1);
endmodule

// File: tb/tb_tw4_system.sv
module tb_tw4_system;
  import tw4_system_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] in;
  logic [3:0] out;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [7:0]  sb[$];
  logic [3:0]  last_out = '0;
  int unsigned count = 0;

  always #5 clock = ~clock;

  tw4_system dut (
    .clock (clock),
    .reset (reset),
    .in    (in),
    .out   (out)
  );

  // Standalone button pair and ROM for block-level checks.
  tw4_system_if tb_bus ();
  wire  tb_irq_net;
  logic [1:0] tb_in;
  logic tb_ieo0, tb_ieo1;

  memory u_rom (.bus(tb_bus.slave));

  button u_b0 (.clock(clock), .in(tb_in[0]), .ack(tb_bus.ack), .ie(tb_bus.ie[0]),
               .iei(1'b1), .ieo(tb_ieo0), .irq(tb_irq_net));
  button u_b1 (.clock(clock), .in(tb_in[1]), .ack(tb_bus.ack), .ie(tb_bus.ie[1]),
               .iei(tb_ieo0), .ieo(tb_ieo1), .irq(tb_irq_net));

  assign tb_bus.irq = (tb_irq_net === 1'b1);

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rom_ref(input int unsigned a);
    case (a)
      0:       return 8'h81;
      1:       return 8'h70;
      2:       return 8'hB0;
      12:      return 8'h51;
      13:      return 8'h90;
      14:      return 8'hA0;
      default: return 8'hF3;
    endcase
  endfunction

  // Every LED change while out of reset must match the next queued value.
  always begin
    @(posedge clock);
    #1;
    if (!reset) begin
      last_out = out;
    end else if (out !== last_out) begin
      if (sb.size() == 0)
        check("unexpected_out_change", {4'h0, out}, {4'h0, last_out});
      else
        check("scoreboard_out", {4'h0, out}, sb.pop_front());
      last_out = out;
    end
  end

  task automatic press_expect();
    count++;
    sb.push_back(8'(count & 4'hF));
  endtask

  task automatic drain(input string tag, input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
    end
    check(tag, 8'(sb.size()), 8'd0);
  endtask

  initial begin
    logic irq_seen;
    logic found;
    reset = 1'b0;
    in = '0;
    tb_in = '0;
    tb_bus.ack = 1'b0;
    tb_bus.ie = '0;
    tb_bus.addr = '0;

    // Reset
    repeat (2) @(negedge clock);
    check("reset_out", {4'h0, out}, 8'h00);
    check("reset_pc", {4'h0, dut.u_cpu.pc}, 8'h00);
    reset = 1'b1;
    @(negedge clock);
    check("ie_after_first", {4'h0, dut.u_cpu.ie}, 8'h01);
    repeat (5) @(negedge clock);
    check("idle_pc", {4'h0, dut.u_cpu.pc}, 8'h03);
    check("idle_irq", {7'h0, dut.bus.irq}, 8'h00);

    // Single held press
    in[0] = 1'b1;
    press_expect();
    drain("press1_drain", 8);
    repeat (20) @(negedge clock);
    check("held_out", {4'h0, out}, 8'h01);
    in[0] = 1'b0;
    repeat (5) @(negedge clock);

    // Reset, then three 250 ns press/release cycles
    reset = 1'b0;
    @(negedge clock);
    check("reset2_out", {4'h0, out}, 8'h00);
    count = 0;
    reset = 1'b1;
    repeat (4) @(negedge clock);
    for (int k = 1; k <= 3; k++) begin
      in[0] = 1'b1;
      press_expect();
      repeat (13) @(negedge clock);
      in[0] = 1'b0;
      repeat (12) @(negedge clock);
      check("press_cycle_drain", 8'(sb.size()), 8'd0);
    end
    check("three_presses_out", {4'h0, out}, 8'h03);

    // Disabled button 1 never raises irq
    irq_seen = 1'b0;
    for (int p = 0; p < 3; p++) begin
      in[1] = 1'b1;
      repeat (2) begin @(negedge clock); irq_seen |= dut.bus.irq; end
      in[1] = 1'b0;
      repeat (2) begin @(negedge clock); irq_seen |= dut.bus.irq; end
    end
    check("disabled_irq", {7'h0, irq_seen}, 8'h00);
    check("disabled_out", {4'h0, out}, 8'h03);

    // Reset while inside the ISR at PC=D
    in[0] = 1'b1;
    press_expect();
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (dut.u_cpu.pc === 4'hD) begin found = 1'b1; break; end
    end
    check("reach_pc_d", {7'h0, found}, 8'h01);
    reset = 1'b0;
    sb.delete();
    count = 0;
    #1;
    check("isr_reset_out", {4'h0, out}, 8'h00);
    check("isr_reset_in_isr", {7'h0, dut.u_cpu.in_isr}, 8'h00);
    check("isr_reset_spc", {4'h0, dut.u_cpu.spc}, 8'h00);
    @(negedge clock);
    check("isr_reset_pending", {7'h0, dut.g_button[0].u_button.pending}, 8'h00);
    reset = 1'b1;
    check("release_pc", {4'h0, dut.u_cpu.pc}, 8'h00);
    repeat (8) @(negedge clock);
    check("no_stale_pending", {7'h0, dut.g_button[0].u_button.pending}, 8'h00);
    check("post_reset_out", {4'h0, out}, 8'h00);
    in[0] = 1'b0;
    repeat (3) @(negedge clock);
    in[0] = 1'b1;
    press_expect();
    drain("post_reset_press_drain", 8);
    in[0] = 1'b0;

    // Button chain priority and acknowledge
    tb_bus.ie = 4'b0011;
    @(negedge clock);
    tb_in = 2'b11;
    @(negedge clock);
    check("both_ieo0", {7'h0, tb_ieo0}, 8'h00);
    check("both_ieo1", {7'h0, tb_ieo1}, 8'h00);
    check("both_irq", {7'h0, tb_bus.irq}, 8'h01);
    tb_bus.ack = 1'b1;
    @(negedge clock);
    tb_bus.ack = 1'b0;
    check("ack1_ieo0", {7'h0, tb_ieo0}, 8'h01);
    check("ack1_irq", {7'h0, tb_bus.irq}, 8'h01);
    check("ack1_ieo1", {7'h0, tb_ieo1}, 8'h00);
    tb_bus.ack = 1'b1;
    @(negedge clock);
    tb_bus.ack = 1'b0;
    check("ack2_irq", {7'h0, tb_bus.irq}, 8'h00);
    check("ack2_ieo1", {7'h0, tb_ieo1}, 8'h01);

    // New edge coinciding with acknowledge keeps the request
    tb_in[0] = 1'b0;
    @(negedge clock);
    tb_in[0] = 1'b1;
    @(negedge clock);
    tb_in[0] = 1'b0;
    @(negedge clock);
    tb_in[0] = 1'b1;
    tb_bus.ack = 1'b1;
    @(negedge clock);
    tb_bus.ack = 1'b0;
    check("edge_ack_irq", {7'h0, tb_bus.irq}, 8'h01);
    check("edge_ack_ieo0", {7'h0, tb_ieo0}, 8'h00);
    tb_bus.ack = 1'b1;
    @(negedge clock);
    tb_bus.ack = 1'b0;
    check("edge_ack_clear", {7'h0, tb_bus.irq}, 8'h00);

    // Enable low drops requests and blocks new edges
    tb_in = 2'b00;
    @(negedge clock);
    tb_in[1] = 1'b1;
    @(negedge clock);
    check("b1_alone_irq", {7'h0, tb_bus.irq}, 8'h01);
    tb_bus.ie = 4'b0000;
    @(negedge clock);
    check("ie_low_clears", {7'h0, tb_bus.irq}, 8'h00);
    tb_in[1] = 1'b0;
    @(negedge clock);
    tb_in[1] = 1'b1;
    @(negedge clock);
    check("ie_low_blocks", {7'h0, tb_bus.irq}, 8'h00);

    // ROM contents
    for (int unsigned a = 0; a < 16; a++) begin
      tb_bus.addr = 4'(a);
      #1;
      check("rom_word", tb_bus.data, rom_ref(a));
    end

    check("final_queue_empty", 8'(sb.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
